dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder for the single-cycle rv32i core. It is the slave end of the core's data port.
- Accepts word, halfword and byte read/write requests.
- Inserts a configurable number of wait states.
- Applies byte-lane write masks.
- Returns the full aligned 32-bit word with a one-cycle valid pulse; the core performs lane extraction and sign extension.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, minimum 4.
LATENCY, 1, wait-state cycles between request acceptance and response; range 0..15.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
ip_data_addr  input  32  byte address from core
ip_data_wr  input  1  write request, level
ip_data_mask  input  4  byte-lane enables (bit n = byte n of word)
ip_data_from_proc  input  32  store data, already lane-aligned by core
ip_data_rd  input  1  read request, level
op_data_valid  output  1  one-cycle response strobe
op_data_to_proc  output  32  full word read from memory

Behaviour:
Word index and reset:
- Word index = ip_data_addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias modulo 4*DEPTH_WORDS.
- ip_data_addr[1:0] is ignored for indexing.
- Reset (synchronous): state=IDLE, op_data_valid=0, op_data_to_proc=0, counter=0. Memory contents are not reset.

FSM states: IDLE, WAIT, RESP.
- IDLE: when ip_data_rd|ip_data_wr=1, latch addr, mask, data and wr into request registers.
  - LATENCY=0: next=RESP.
  - LATENCY>0: counter=LATENCY, next=WAIT.
- WAIT: counter decrements each cycle. When counter==1, next=RESP. Request inputs are ignored (latched copies are used).
- RESP entry edge (the clock edge that moves into RESP):
  - op_data_to_proc <= mem[index], the pre-write value (read-before-write).
  - If latched wr=1, mem[index] byte n <= data byte n for each mask bit n set.
  - op_data_valid <= 1.
- RESP: lasts exactly one cycle, op_data_valid=1, next=IDLE unconditionally. op_data_valid <= 0 on exit.

Latency:
- Response appears LATENCY+1 cycles after the acceptance edge.
- Total request-to-next-acceptance spacing is at least LATENCY+2 cycles, because one IDLE cycle is always inserted after RESP.

Core obligation: hold the request stable until it samples op_data_valid=1, and drop or replace it in the following cycle.

Boundary conditions:
- rd and wr both set: treated as a write; op_data_to_proc returns the old word.
- Mask 0000 with wr=1: no bytes change; the response still occurs.
- op_data_to_proc holds its value until the next RESP entry; it is not cleared in IDLE.
- Reset before the RESP entry edge: the request is aborted and no write is performed.
- Reset asserted during RESP: valid stays 1 that cycle (registered), then returns to 0. The write has already committed.
- Counter width is 4 bits. The LATENCY range is checked at elaboration.

Optional Feature:
DMEM_MISALIGN_CHECK_EN.
- Defined: adds output port op_data_err (1 bit, reset 0), asserted only alongside op_data_valid. A request is an error if the latched mask/addr pair is not one of:
  - 1111 with addr[1:0]=00
  - 0011 with addr[1:0]=00
  - 1100 with addr[1:0]=10
  - one-hot mask with bit index == addr[1:0]
  - On error: write suppressed, op_data_to_proc=0, op_data_err=1 for the RESP cycle.
  - rd/wr with mask 0000 is also an error.
- Undefined: no port and no checking; all masks are accepted as given.

Decomposition:
- Package dmem_pkg: state encoding (IDLE/WAIT/RESP); legal mask constants (MASK_WORD, MASK_HALF_LO, MASK_HALF_HI, MASK_BYTE0..3); counter width constant.
- Sub-module dmem_sram: DEPTH_WORDS×32 array, single port, synchronous read-before-write, 4 byte write enables. Instantiated once.
- dmem_responder: FSM, counter and request registers only.

Test Plan:
1. LATENCY=1, write addr 0x10 data 0xDEADBEEF mask 1111, then read 0x10. Required: valid 2 cycles after each acceptance; read returns 0xDEADBEEF.
2. Byte store:
   - Preload word 0x10 = 0x11223344, write addr 0x12 data 0x00AB0000 mask 0100, then read 0x10 -> 0x11AB3344.
   - Halfword store to 0x12 with data 0xCAFE0000 mask 1100 -> 0xCAFE3344.
3. LATENCY=0 and LATENCY=3, back-to-back reads of 0x0, 0x4: valid after 1 and 4 cycles respectively; exactly one IDLE cycle between RESP and the next acceptance.
4. Write 0x55AA55AA to addr 0x0 with rd=wr=1 over old 0x01020304: response data 0x01020304; subsequent read 0x55AA55AA.
5. Reset in WAIT (LATENCY=3, cycle 2) during a write of 0xFFFFFFFF to 0x8 holding 0x0: no valid; a later read of 0x8 returns 0x0. Address 4*DEPTH_WORDS+8 aliases to 0x8.
6. With DMEM_MISALIGN_CHECK_EN, word write at 0x21 mask 1111: op_data_err=1 with valid, data 0, memory unchanged. Without the macro, the same write updates word 0x20.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, legal lane masks,
// wait-state counter width and the mask/offset legality helper.
package dmem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [3:0] MASK_WORD    = 4'b1111;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_BYTE1   = 4'b0010;
    localparam logic [3:0] MASK_BYTE2   = 4'b0100;
    localparam logic [3:0] MASK_BYTE3   = 4'b1000;

    // True when the lane mask is a naturally aligned access for the byte offset.
    function automatic logic dmem_pair_legal(input logic [3:0] mask, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (mask)
            MASK_WORD:    ok = (off == 2'b00);
            MASK_HALF_LO: ok = (off == 2'b00);
            MASK_HALF_HI: ok = (off == 2'b10);
            MASK_BYTE0:   ok = (off == 2'b00);
            MASK_BYTE1:   ok = (off == 2'b01);
            MASK_BYTE2:   ok = (off == 2'b10);
            MASK_BYTE3:   ok = (off == 2'b11);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with byte-lane write enables and a registered,
// read-before-write data output that clears on reset.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       we,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];
    logic [31:0] rdata_r;

    // Storage array: only enabled lanes are written, contents survive reset
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read port samples the pre-write word on the same edge as the write
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= 32'h0000_0000;
        end else if (en) begin
            rdata_r <= mem_r[idx];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-port slave for the rv32i core: request latch, wait-state FSM, one-cycle response.
// Optional misaligned-access checking with op_data_err is enabled by DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ip_data_addr,
    input  logic        ip_data_wr,
    input  logic [3:0]  ip_data_mask,
    input  logic [31:0] ip_data_from_proc,
    input  logic        ip_data_rd,
    output logic        op_data_valid,
    output logic [31:0] op_data_to_proc
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic        op_data_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 0..15");
    end
    if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two, at least 4");
    end

    dmem_state_e      state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W-1:0] idx_r, eff_idx_s;
    logic [3:0]       mask_r, eff_mask_s, sram_we_s;
    logic [31:0]      data_r, eff_data_s, sram_rdata_s;
    logic             wr_r, eff_wr_s;
    logic             req_s, accept_s, entry_s, valid_r;
    logic             unused_addr_s;

    assign req_s = ip_data_rd | ip_data_wr;

`ifdef DMEM_MISALIGN_CHECK_EN
    logic [1:0] off_r, eff_off_s;
    logic       err_s, err_r, zero_hold_r;
    assign unused_addr_s = ^ip_data_addr[31:IDX_W+2];
`else
    assign unused_addr_s = ^{ip_data_addr[31:IDX_W+2], ip_data_addr[1:0]};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_next_s = (LATENCY == 0) ? RESP : WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: acceptance, RESP-entry strobe and the request in force at that edge.
    // With zero wait states the entry edge is the acceptance edge, so the live inputs are used.
    always_comb begin
        accept_s   = 1'b0;
        entry_s    = 1'b0;
        eff_idx_s  = idx_r;
        eff_mask_s = mask_r;
        eff_data_s = data_r;
        eff_wr_s   = wr_r;
`ifdef DMEM_MISALIGN_CHECK_EN
        eff_off_s  = off_r;
`endif
        case (state_r)
            IDLE: begin
                accept_s   = req_s;
                entry_s    = req_s && (LATENCY == 0);
                eff_idx_s  = ip_data_addr[IDX_W+1:2];
                eff_mask_s = ip_data_mask;
                eff_data_s = ip_data_from_proc;
                eff_wr_s   = ip_data_wr;
`ifdef DMEM_MISALIGN_CHECK_EN
                eff_off_s  = ip_data_addr[1:0];
`endif
            end
            WAIT:    entry_s = (cnt_r == CNT_W'(1));
            RESP:    entry_s = 1'b0;
            default: entry_s = 1'b0;
        endcase
        entry_s = entry_s & ~reset;
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign err_s     = ~dmem_pair_legal(eff_mask_s, eff_off_s);
    assign sram_we_s = (entry_s && eff_wr_s && !err_s) ? eff_mask_s : 4'b0000;
`else
    assign sram_we_s = (entry_s && eff_wr_s) ? eff_mask_s : 4'b0000;
`endif

    // Request latch and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            idx_r  <= {IDX_W{1'b0}};
            mask_r <= 4'b0000;
            data_r <= 32'h0000_0000;
            wr_r   <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
            off_r  <= 2'b00;
`endif
        end else if (accept_s) begin
            cnt_r  <= CNT_W'(LATENCY);
            idx_r  <= ip_data_addr[IDX_W+1:2];
            mask_r <= ip_data_mask;
            data_r <= ip_data_from_proc;
            wr_r   <= ip_data_wr;
`ifdef DMEM_MISALIGN_CHECK_EN
            off_r  <= ip_data_addr[1:0];
`endif
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Response strobe, high exactly for the RESP cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= entry_s;
        end
    end

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk   (clk),
        .reset (reset),
        .en    (entry_s),
        .we    (sram_we_s),
        .idx   (eff_idx_s),
        .wdata (eff_data_s),
        .rdata (sram_rdata_s)
    );

    assign op_data_valid = valid_r;

`ifdef DMEM_MISALIGN_CHECK_EN
    // Error flag for the RESP cycle; the zero-hold masks read data until the next response
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r       <= 1'b0;
            zero_hold_r <= 1'b0;
        end else if (entry_s) begin
            err_r       <= err_s;
            zero_hold_r <= err_s;
        end else begin
            err_r       <= 1'b0;
            zero_hold_r <= zero_hold_r;
        end
    end

    assign op_data_err     = err_r;
    assign op_data_to_proc = zero_hold_r ? 32'h0000_0000 : sram_rdata_s;
`else
    assign op_data_to_proc = sram_rdata_s;
`endif

endmodule
